// File: rtl/datapath_seq_ctrl.sv
// Multi-cycle IDLE/DEC/EXE/WB sequencer for the decode/reg_file/alu datapath.
// Optional overflow trap (WB suppresses the write and parks in HALT) enabled by `define OVF_TRAP_EN.
module datapath_seq_ctrl #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_valid_i,
    input  logic [DWIDTH-1:0]    instr_in_i,
    output logic                 instr_ready_o,
    input  logic                 halt_req_i,
    output logic [DWIDTH-1:0]    ir_o,
    input  logic [4:0]           rdst_id_in_i,
    input  logic [DWIDTH-1:0]    alu_rd_i,
    input  logic                 alu_overflow_i,
    output logic                 we_o,
    output logic [4:0]           wb_id_o,
    output logic [DWIDTH-1:0]    wb_data_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] retired_o,
    output logic                 halted_o
);

`ifdef OVF_TRAP_EN
    typedef enum logic [2:0] {StIdle, StDec, StExe, StWb, StHalt} state_e;
`else
    typedef enum logic [1:0] {StIdle, StDec, StExe, StWb} state_e;
`endif

    state_e                 state_q, state_d;
    logic [DWIDTH-1:0]      ir_q, ir_d;
    logic [DWIDTH-1:0]      wb_data_q, wb_data_d;
    logic [4:0]             wb_id_q, wb_id_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;
    logic                   trap_pending;
    logic                   accept;

`ifdef OVF_TRAP_EN
    logic ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (state_q == StExe) begin
            ovf_q <= alu_overflow_i;
        end
    end

    assign trap_pending = ovf_q;
    assign halted_o     = (state_q == StHalt);
`else
    logic unused_ovf;
    assign unused_ovf   = alu_overflow_i;
    assign trap_pending = 1'b0;
    assign halted_o     = 1'b0;
`endif

    // A WB that is about to trap must not hand over to a new instruction.
    assign instr_ready_o = (state_q == StIdle || (state_q == StWb && !trap_pending)) && !halt_req_i;
    assign accept        = instr_valid_i && instr_ready_o;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wb_data_d = wb_data_q;
        wb_id_d   = wb_id_q;
        retired_d = retired_q;
        we_o      = 1'b0;
        busy_o    = 1'b0;

        if (accept) begin
            ir_d = instr_in_i;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StDec;
            end
            StDec: begin
                busy_o  = 1'b1;
                state_d = StExe;
            end
            StExe: begin
                busy_o    = 1'b1;
                wb_data_d = alu_rd_i;
                wb_id_d   = rdst_id_in_i;
                state_d   = StWb;
            end
            StWb: begin
                busy_o = 1'b1;
`ifdef OVF_TRAP_EN
                if (trap_pending) state_d = StHalt;
                else
`endif
                begin
                    we_o = 1'b1;
                    if (retired_q != {CNT_WIDTH{1'b1}}) begin
                        retired_d = retired_q + CNT_WIDTH'(1);
                    end
                    state_d = accept ? StDec : StIdle;
                end
            end
`ifdef OVF_TRAP_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            wb_data_q <= '0;
            wb_id_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wb_data_q <= wb_data_d;
            wb_id_q   <= wb_id_d;
            retired_q <= retired_d;
        end
    end

    assign ir_o      = ir_q;
    assign wb_id_o   = wb_id_q;
    assign wb_data_o = wb_data_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Self-checking bench for datapath_seq_ctrl: directed scenarios plus random traffic against a
// timestamp-based reference model (each accepted instruction writes back three cycles later).
module tb_datapath_seq_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic [DW-1:0] instr_in;
    logic          instr_ready;
    logic          halt_req;
    logic [DW-1:0] ir;
    logic [4:0]    rdst_id;
    logic [DW-1:0] alu_rd;
    logic          alu_ovf;
    logic          we;
    logic [4:0]    wb_id;
    logic [DW-1:0] wb_data;
    logic          busy;
    logic [CW-1:0] retired;
    logic          halted;

    always #5 clk = ~clk;

    // Stand-in datapath: result = instr + 1, destination = instr[4:0] ^ 7.
    assign rdst_id = ir[4:0] ^ 5'd7;
    assign alu_rd  = ir + 32'd1;
    assign alu_ovf = (ir == 32'h7FFF_FFFF);

    datapath_seq_ctrl #(.DWIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_valid_i  (instr_valid),
        .instr_in_i     (instr_in),
        .instr_ready_o  (instr_ready),
        .halt_req_i     (halt_req),
        .ir_o           (ir),
        .rdst_id_in_i   (rdst_id),
        .alu_rd_i       (alu_rd),
        .alu_overflow_i (alu_ovf),
        .we_o           (we),
        .wb_id_o        (wb_id),
        .wb_data_o      (wb_data),
        .busy_o         (busy),
        .retired_o      (retired),
        .halted_o       (halted)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: cycle counter and timestamp of the last accept.
    int          cyc = 0;
    int          acc_cyc = -100;
    logic [4:0]  p_id, m_wb_id;
    logic [31:0] p_data, m_wb_data, m_ir;
    bit          p_ovf, m_halted;
    int          m_retired;
    int          we_pulses, accepts;

    function automatic int phase();
        return cyc - acc_cyc;
    endfunction

    function automatic bit m_trap_now();
`ifdef OVF_TRAP_EN
        return phase() == 3 && p_ovf;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_busy();
        return phase() >= 1 && phase() <= 3;
    endfunction

    function automatic bit m_we();
        return phase() == 3 && !m_trap_now();
    endfunction

    function automatic bit m_ready();
        return !(phase() == 1 || phase() == 2) && !m_trap_now() && !halt_req && !m_halted;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("we", {31'b0, we}, {31'b0, m_we()});
        check("busy", {31'b0, busy}, {31'b0, m_busy()});
        check("ir", ir, m_ir);
        check("wb_id", {27'b0, wb_id}, {27'b0, m_wb_id});
        check("wb_data", wb_data, m_wb_data);
        check("retired", {29'b0, retired}, m_retired);
        check("halted", {31'b0, halted}, {31'b0, m_halted});
    endtask

    task automatic model_edge(input bit acc);
        int ph = phase();
        if (ph == 2) begin
            m_wb_id   = p_id;
            m_wb_data = p_data;
        end
        if (ph == 3) begin
            if (m_trap_now()) m_halted = 1'b1;
            else if (m_retired < (1 << CW) - 1) m_retired++;
        end
        if (acc) begin
            m_ir    = instr_in;
            p_id    = instr_in[4:0] ^ 5'd7;
            p_data  = instr_in + 32'd1;
            p_ovf   = (instr_in == 32'h7FFF_FFFF);
            acc_cyc = cyc;
        end
        cyc++;
    endtask

    // One clock cycle: check registered state, apply inputs, check ready, advance model.
    task automatic drive(input bit v, input logic [31:0] ins, input bit h);
        bit acc;
        @(negedge clk);
        check_outputs();
        we_pulses += int'(we);
        instr_valid = v;
        instr_in    = ins;
        halt_req    = h;
        #1;
        check("instr_ready", {31'b0, instr_ready}, {31'b0, m_ready()});
        acc = v && m_ready();
        accepts += int'(acc);
        model_edge(acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        halt_req    = 1'b0;
        #1;
        acc_cyc   = cyc - 100;
        m_ir      = '0;
        m_wb_id   = '0;
        m_wb_data = '0;
        m_retired = 0;
        m_halted  = 1'b0;
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd();
        logic [31:0] r = $urandom;
        if (r == 32'h7FFF_FFFF) r = 32'h0;
        return r;
    endfunction

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_in    = '0;
        halt_req    = 1'b0;
        do_reset();

        // Single instruction: result 5 to R3.
        drive(1'b1, 32'd4, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, rnd(), 1'b0);
        check("t1_wb_id", {27'b0, wb_id}, 32'd3);
        check("t1_wb_data", wb_data, 32'd5);
        check("t1_retired", {29'b0, retired}, 32'd1);

        // Valid held: ten accepts, one every three cycles; counter saturates at 7.
        we_pulses = 0;
        accepts   = 0;
        for (int i = 0; i < 30; i++) drive(1'b1, rnd(), 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, rnd(), 1'b0);
        check("t2_accepts", accepts, 32'd10);
        check("t2_we_pulses", we_pulses, 32'd10);
        check("t2_retired_sat", {29'b0, retired}, 32'd7);

        // halt_req raised in EXE: instruction still writes back, then idle and not ready.
        do_reset();
        we_pulses = 0;
        drive(1'b1, rnd(), 1'b0);
        drive(1'b1, rnd(), 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, rnd(), 1'b1);
        check("t3_we_pulses", we_pulses, 32'd1);
        check("t3_busy", {31'b0, busy}, 32'd0);
        check("t3_ready", {31'b0, instr_ready}, 32'd0);
        drive(1'b0, rnd(), 1'b0);

        // Reset in EXE abandons the instruction.
        do_reset();
        drive(1'b1, rnd(), 1'b0);
        drive(1'b0, rnd(), 1'b0);
        we_pulses = 0;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b0, rnd(), 1'b0);
        check("t4_we_pulses", we_pulses, 32'd0);
        check("t4_retired", {29'b0, retired}, 32'd0);
        drive(1'b1, 32'd4, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, rnd(), 1'b0);
        check("t4_retired_after", {29'b0, retired}, 32'd1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, rnd(), $urandom_range(0, 9) < 2);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, rnd(), 1'b0);

        // Overflowing add 0x7FFFFFFF + 1.
        do_reset();
        drive(1'b1, 32'h7FFF_FFFF, 1'b0);
        drive(1'b0, rnd(), 1'b0);
        drive(1'b0, rnd(), 1'b0);
        drive(1'b1, rnd(), 1'b0);
`ifdef OVF_TRAP_EN
        for (int i = 0; i < 4; i++) drive(1'b1, rnd(), 1'b0);
        check("t5_halted", {31'b0, halted}, 32'd1);
        check("t5_retired", {29'b0, retired}, 32'd0);
        check("t5_ready", {31'b0, instr_ready}, 32'd0);
`else
        check("t5_wb_data", wb_data, 32'h8000_0000);
        check("t5_halted", {31'b0, halted}, 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, rnd(), 1'b0);
        check("t5_retired", {29'b0, retired}, 32'd2);
`endif
        do_reset();
        drive(1'b0, rnd(), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
